// File: rtl/cook_timer_controller.sv
// rtl/cook_timer_controller.sv - microwave cook cycle sequencer with BCD countdown
module cook_timer_controller #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter int DONE_BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  input  logic [3:0] set_min,
  input  logic [3:0] set_sec_tens,
  input  logic [3:0] set_sec_units,
  output logic       load_en,
  output logic [3:0] min_out,
  output logic [3:0] sec_tens_out,
  output logic [3:0] sec_units_out,
  output logic       heating,
  output logic       done,
  output logic [1:0] state_out
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = $clog2(DONE_BEEP_SECS + 1);
  localparam logic [PW-1:0] TC       = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_END = BW'(DONE_BEEP_SECS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOK  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [BW-1:0] beep, beep_n;
  logic [3:0]    t_min, t_tens, t_units;
  logic [3:0]    min_n, tens_n, units_n;

  logic          tick;
  logic          digits_ok;
  logic          time_nonzero;
  logic          borrow_tens;
  logic [3:0]    dec_min, dec_tens, dec_units;
  logic          dec_zero;

  // One-second decrement of the held time, with BCD borrows; minutes saturate at 0
  always_comb begin
    tick         = (presc == TC);
    digits_ok    = (set_min <= 4'd9) && (set_sec_tens <= 4'd5) && (set_sec_units <= 4'd9);
    time_nonzero = (set_min != 4'd0) || (set_sec_tens != 4'd0) || (set_sec_units != 4'd0);
    borrow_tens  = (t_units == 4'd0);
    dec_units    = borrow_tens ? 4'd9 : t_units - 4'd1;
    dec_tens     = t_tens;
    dec_min      = t_min;
    if (borrow_tens) begin
      if (t_tens == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = (t_min == 4'd0) ? 4'd0 : t_min - 4'd1;
      end else begin
        dec_tens = t_tens - 4'd1;
      end
    end
    dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_units == 4'd0);
  end

  // Next-state and next-data; priority stop_clear > door_open > start > tick
  always_comb begin
    state_n = state;
    presc_n = presc;
    beep_n  = beep;
    min_n   = t_min;
    tens_n  = t_tens;
    units_n = t_units;
    case (state)
      IDLE: begin
        // Only BCD digits are mirrored so the time regs never hold a non-BCD code
        if (set_min <= 4'd9)       min_n   = set_min;
        if (set_sec_tens <= 4'd9)  tens_n  = set_sec_tens;
        if (set_sec_units <= 4'd9) units_n = set_sec_units;
        if (!stop_clear && !door_open && start && digits_ok && time_nonzero) begin
          state_n = COOK;
          presc_n = '0;
        end
      end
      COOK: begin
        if (stop_clear || door_open) begin
          state_n = PAUSE;
        end else if (tick) begin
          presc_n = '0;
          min_n   = dec_min;
          tens_n  = dec_tens;
          units_n = dec_units;
          if (dec_zero) begin
            state_n = DONE;
            beep_n  = '0;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          state_n = IDLE;
          min_n   = 4'd0;
          tens_n  = 4'd0;
          units_n = 4'd0;
        end else if (!door_open && start) begin
          state_n = COOK;
        end
      end
      DONE: begin
        if (stop_clear || door_open) begin
          state_n = IDLE;
          presc_n = '0;
          beep_n  = '0;
        end else if (tick) begin
          presc_n = '0;
          if (beep == BEEP_END) begin
            state_n = IDLE;
            beep_n  = '0;
          end else begin
            beep_n = beep + 1'b1;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      beep    <= '0;
      t_min   <= 4'd0;
      t_tens  <= 4'd0;
      t_units <= 4'd0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      beep    <= beep_n;
      t_min   <= min_n;
      t_tens  <= tens_n;
      t_units <= units_n;
    end
  end

  // Outputs are registers or pure decodes of the state
  always_comb begin
    load_en       = (state == IDLE);
    heating       = (state == COOK);
    done          = (state == DONE);
    state_out     = state;
    min_out       = t_min;
    sec_tens_out  = t_tens;
    sec_units_out = t_units;
  end

endmodule

// File: tb/tb_cook_timer_controller.sv
// tb/tb_cook_timer_controller.sv - directed self-checking bench for cook_timer_controller
module tb_cook_timer_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop_clear, door_open;
  logic [3:0] set_min, set_sec_tens, set_sec_units;
  logic       load_en, heating, done;
  logic [3:0] min_out, sec_tens_out, sec_units_out;
  logic [1:0] state_out;

  int errors = 0;
  int checks = 0;

  cook_timer_controller #(.TICKS_PER_SEC(4), .DONE_BEEP_SECS(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop_clear    (stop_clear),
    .door_open     (door_open),
    .set_min       (set_min),
    .set_sec_tens  (set_sec_tens),
    .set_sec_units (set_sec_units),
    .load_en       (load_en),
    .min_out       (min_out),
    .sec_tens_out  (sec_tens_out),
    .sec_units_out (sec_units_out),
    .heating       (heating),
    .done          (done),
    .state_out     (state_out)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u);
    set_min = m; set_sec_tens = t; set_sec_units = u;
    step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_clear = 1'b1; step(1); stop_clear = 1'b0;
  endtask

  function automatic logic [15:0] disp();
    return {4'h0, min_out, sec_tens_out, sec_units_out};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop_clear = 1'b0; door_open = 1'b0;
    set_min = 4'd0; set_sec_tens = 4'd0; set_sec_units = 4'd0;
    step(2);
    rst = 1'b0;
    check("rst_state", 16'(state_out), 16'd0);
    check("rst_load_en", 16'(load_en), 16'd1);
    check("rst_heating", 16'(heating), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_time", disp(), 16'h000);

    // 0:12 full run to DONE and automatic return to IDLE
    set_time(4'd0, 4'd1, 4'd2);
    check("idle_display", disp(), 16'h012);
    pulse_start();
    check("t1_state_cook", 16'(state_out), 16'd1);
    check("t1_heating", 16'(heating), 16'd1);
    check("t1_load_en", 16'(load_en), 16'd0);
    step(3);
    check("t1_3clk", disp(), 16'h012);
    step(1);
    check("t1_4clk", disp(), 16'h011);
    step(43);
    check("t1_47clk_state", 16'(state_out), 16'd1);
    check("t1_47clk_time", disp(), 16'h001);
    step(1);
    check("t1_done_state", 16'(state_out), 16'd3);
    check("t1_done", 16'(done), 16'd1);
    check("t1_done_heating", 16'(heating), 16'd0);
    check("t1_done_time", disp(), 16'h000);
    step(7);
    check("t1_done_8th", 16'(done), 16'd1);
    step(1);
    check("t1_back_idle", 16'(state_out), 16'd0);
    check("t1_load_en_idle", 16'(load_en), 16'd1);

    // 1:00 -> 0:59 ... 0:50 -> 0:49
    set_time(4'd1, 4'd0, 4'd0);
    pulse_start();
    step(4);
    check("t2_059", disp(), 16'h059);
    step(36);
    check("t2_050", disp(), 16'h050);
    step(4);
    check("t2_049", disp(), 16'h049);
    pulse_stop();
    check("t2_pause", 16'(state_out), 16'd2);
    check("t2_pause_heating", 16'(heating), 16'd0);
    pulse_stop();
    check("t2_clear_idle", 16'(state_out), 16'd0);
    check("t2_clear_time", disp(), 16'h000);

    // Door opened with a tick pending; tick applies on first COOK clk after resume
    set_time(4'd0, 4'd3, 4'd0);
    pulse_start();
    step(3);
    door_open = 1'b1;
    step(1);
    check("t3_pause", 16'(state_out), 16'd2);
    check("t3_held", disp(), 16'h030);
    pulse_start();
    check("t3_door_blocks", 16'(state_out), 16'd2);
    step(3);
    check("t3_still_held", disp(), 16'h030);
    door_open = 1'b0;
    pulse_start();
    check("t3_resume", 16'(state_out), 16'd1);
    check("t3_resume_time", disp(), 16'h030);
    step(1);
    check("t3_first_tick", disp(), 16'h029);
    step(88);
    check("t3_007", disp(), 16'h007);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t3_rst_state", 16'(state_out), 16'd0);
    check("t3_rst_time", disp(), 16'h000);
    check("t3_rst_heating", 16'(heating), 16'd0);
    check("t3_rst_done", 16'(done), 16'd0);

    // stop_clear in DONE returns to IDLE on the next clk
    set_time(4'd0, 4'd0, 4'd1);
    pulse_start();
    step(4);
    check("t4_done", 16'(done), 16'd1);
    pulse_stop();
    check("t4_stop_idle", 16'(state_out), 16'd0);
    check("t4_stop_done", 16'(done), 16'd0);

    // Rejected starts
    set_time(4'd0, 4'd0, 4'd0);
    pulse_start();
    check("t5_zero_start", 16'(state_out), 16'd0);
    check("t5_zero_heat", 16'(heating), 16'd0);
    set_time(4'd0, 4'd6, 4'd1);
    pulse_start();
    check("t5_tens6_start", 16'(state_out), 16'd0);
    check("t5_tens6_heat", 16'(heating), 16'd0);
    set_time(4'd0, 4'd0, 4'd5);
    door_open = 1'b1;
    pulse_start();
    check("t5_door_start", 16'(state_out), 16'd0);
    check("t5_door_heat", 16'(heating), 16'd0);
    door_open = 1'b0;

    // start and stop_clear together in PAUSE: clear wins
    pulse_start();
    check("t6_cook", 16'(state_out), 16'd1);
    pulse_stop();
    check("t6_pause", 16'(state_out), 16'd2);
    start = 1'b1; stop_clear = 1'b1;
    step(1);
    start = 1'b0; stop_clear = 1'b0;
    check("t6_idle", 16'(state_out), 16'd0);
    check("t6_time_cleared", disp(), 16'h000);

    // Maximum time decrements normally
    set_time(4'd9, 4'd5, 4'd9);
    pulse_start();
    step(4);
    check("t7_958", disp(), 16'h958);
    pulse_stop();
    pulse_stop();
    check("t7_idle", 16'(state_out), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
